// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port memory arbiter.
`default_nettype none

package mem_arb_pkg;

    localparam int ADDR_SIZE = 13;
    localparam int WORD_SIZE = 32;

    typedef logic port_id_t;

    localparam port_id_t PORT_IF = 1'b0;
    localparam port_id_t PORT_LS = 1'b1;

    typedef struct packed {
        logic                 write;
        logic [ADDR_SIZE-1:0] addr;
        logic [WORD_SIZE-1:0] wdata;
    } mem_cmd_t;

    typedef struct packed {
        logic     valid;
        port_id_t port;
    } tag_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant with a registered last-winner pointer.
`default_nettype none

module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic [1:0] Req,
    output logic [1:0] Gnt
);

    port_id_t last;

    // On a tie the port that did not win most recently is served.
    always_comb begin
        Gnt = 2'b00;
        if (Req[0] && (!Req[1] || last == PORT_LS)) begin
            Gnt[0] = 1'b1;
        end else if (Req[1]) begin
            Gnt[1] = 1'b1;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            last <= PORT_LS;
        end else if (Gnt[0]) begin
            last <= PORT_IF;
        end else if (Gnt[1]) begin
            last <= PORT_LS;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous memory between fetch and load/store ports,
// registering the winning command and routing read data back via a tag pipeline.
`default_nettype none

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AddressSize = ADDR_SIZE,
    parameter int WordSize    = WORD_SIZE
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Req0,
    input  logic                   Write0,
    input  logic [AddressSize-1:0] Addr0,
    input  logic [WordSize-1:0]    WData0,
    output logic                   Ack0,
    output logic                   RValid0,
    output logic [WordSize-1:0]    RData0,
    input  logic                   Req1,
    input  logic                   Write1,
    input  logic [AddressSize-1:0] Addr1,
    input  logic [WordSize-1:0]    WData1,
    output logic                   Ack1,
    output logic                   RValid1,
    output logic [WordSize-1:0]    RData1,
    output logic                   MemWriteEn,
    output logic                   MemReadEn,
    output logic [AddressSize-1:0] MemAddress,
    output logic [WordSize-1:0]    MemWriteData,
    input  logic [WordSize-1:0]    MemReadData
);

    logic [1:0]             gnt;
    logic                   granted;
    port_id_t               sel_port;
    logic                   sel_write;
    logic [AddressSize-1:0] sel_addr;
    logic [WordSize-1:0]    sel_wdata;
    tag_t                   tag_s0;
    tag_t                   tag_s1;

    rr_arbiter2 u_rr (
        .Clock (Clock),
        .Reset (Reset),
        .Req   ({Req1, Req0}),
        .Gnt   (gnt)
    );

    assign Ack0      = gnt[0];
    assign Ack1      = gnt[1];
    assign granted   = |gnt;
    assign sel_port  = gnt[1] ? PORT_LS : PORT_IF;
    assign sel_write = gnt[1] ? Write1 : Write0;
    assign sel_addr  = gnt[1] ? Addr1  : Addr0;
    assign sel_wdata = gnt[1] ? WData1 : WData0;

    // Stage 0 tracks the command on the memory bus, stage 1 the cycle its data returns.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            MemWriteEn   <= 1'b0;
            MemReadEn    <= 1'b0;
            MemAddress   <= '0;
            MemWriteData <= '0;
            tag_s0       <= '0;
            tag_s1       <= '0;
        end else begin
            MemWriteEn   <= granted && sel_write;
            MemReadEn    <= granted && !sel_write;
            if (granted) begin
                MemAddress   <= sel_addr;
                MemWriteData <= sel_wdata;
            end
            tag_s0.valid <= granted && !sel_write;
            tag_s0.port  <= sel_port;
            tag_s1       <= tag_s0;
        end
    end

    assign RValid0 = tag_s1.valid && (tag_s1.port == PORT_IF);
    assign RValid1 = tag_s1.valid && (tag_s1.port == PORT_LS);
    assign RData0  = RValid0 ? MemReadData : '0;
    assign RData1  = RValid1 ? MemReadData : '0;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table, directed and random checks of mem_arbiter against a grant-order model.
`default_nettype none

module tb_mem_arbiter;

    localparam int AW = 13;
    localparam int DW = 32;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          Req0, Write0, Req1, Write1;
    logic [AW-1:0] Addr0, Addr1;
    logic [DW-1:0] WData0, WData1;
    logic          Ack0, Ack1, RValid0, RValid1;
    logic [DW-1:0] RData0, RData1;
    logic          MemWriteEn, MemReadEn;
    logic [AW-1:0] MemAddress;
    logic [DW-1:0] MemWriteData;
    logic [DW-1:0] MemReadData;

    mem_arbiter #(.AddressSize(AW), .WordSize(DW)) dut (
        .Clock(Clock), .Reset(Reset),
        .Req0(Req0), .Write0(Write0), .Addr0(Addr0), .WData0(WData0),
        .Ack0(Ack0), .RValid0(RValid0), .RData0(RData0),
        .Req1(Req1), .Write1(Write1), .Addr1(Addr1), .WData1(WData1),
        .Ack1(Ack1), .RValid1(RValid1), .RData1(RData1),
        .MemWriteEn(MemWriteEn), .MemReadEn(MemReadEn),
        .MemAddress(MemAddress), .MemWriteData(MemWriteData),
        .MemReadData(MemReadData)
    );

    always #5 Clock = ~Clock;

    // Environment memory: single-port, one-cycle read latency.
    logic [DW-1:0] env_mem [0:(1<<AW)-1];
    always @(posedge Clock) begin
        if (MemWriteEn) env_mem[MemAddress] <= MemWriteData;
        if (MemReadEn)  MemReadData <= env_mem[MemAddress];
    end

    // Reference model state: expected memory contents and reads awaiting return.
    typedef struct packed {
        int            due;
        bit            port;
        logic [DW-1:0] data;
    } exp_t;

    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    exp_t          exp_q[$];
    int            m_last = 1;
    int            cyc = 0;
    bit            p_rd = 0, p_wr = 0;
    logic [AW-1:0] p_addr = '0;
    logic [DW-1:0] p_data = '0;

    int n_cmp = 0;
    int n_fail = 0;

    logic          s_ack0, s_ack1, s_rv0, s_rv1;
    logic [DW-1:0] s_rd0, s_rd1;
    bit            g0, g1;

    typedef struct {
        bit r0, r1, a0, a1;
    } vec_t;
    vec_t tbl [12];

    bit            q_act [2];
    bit            q_wr  [2];
    logic [AW-1:0] q_addr[2];
    logic [DW-1:0] q_data[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input int p, input bit req, input bit wr, input int addr, input logic [DW-1:0] data);
        if (p == 0) begin
            Req0 = req; Write0 = wr; Addr0 = AW'(addr); WData0 = data;
        end else begin
            Req1 = req; Write1 = wr; Addr1 = AW'(addr); WData1 = data;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_last = 1;
        p_rd = 0;
        p_wr = 0;
    endtask

    // One clock cycle: check every output against the model, then apply this cycle's grant.
    task automatic step();
        exp_t          r;
        bit            ev;
        bit            gp, gw;
        logic [AW-1:0] ga;
        logic [DW-1:0] gd;
        @(negedge Clock);
        g0 = Req0 && (!Req1 || m_last != 0);
        g1 = Req1 && !g0;
        chk("ack0", Ack0, g0);
        chk("ack1", Ack1, g1);
        ev = 0;
        r  = '0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            r  = exp_q.pop_front();
            ev = 1;
        end
        chk("rvalid0", RValid0, ev && !r.port);
        chk("rvalid1", RValid1, ev && r.port);
        chk("rdata0", RData0, (ev && !r.port) ? r.data : '0);
        chk("rdata1", RData1, (ev && r.port) ? r.data : '0);
        chk("mem_rd_en", MemReadEn, p_rd);
        chk("mem_wr_en", MemWriteEn, p_wr);
        if (p_rd || p_wr) chk("mem_addr", MemAddress, p_addr);
        if (p_wr) chk("mem_wdata", MemWriteData, p_data);
        s_ack0 = Ack0; s_ack1 = Ack1; s_rv0 = RValid0; s_rv1 = RValid1;
        s_rd0 = RData0; s_rd1 = RData1;
        p_rd = 0;
        p_wr = 0;
        if (g0 || g1) begin
            gp = g1;
            gw = g1 ? Write1 : Write0;
            ga = g1 ? Addr1 : Addr0;
            gd = g1 ? WData1 : WData0;
            m_last = gp ? 1 : 0;
            if (gw) begin
                ref_mem[ga] = gd;
                p_wr = 1;
            end else begin
                exp_q.push_back('{due: cyc + 2, port: gp, data: ref_mem[ga]});
                p_rd = 1;
            end
            p_addr = ga;
            p_data = gd;
        end
        cyc++;
        @(posedge Clock);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, '0);
        drive(1, 0, 0, 0, '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        idle();
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_wr_en", MemWriteEn, 0);
        chk("rst_rd_en", MemReadEn, 0);
        chk("rst_addr", MemAddress, 0);
        chk("rst_wdata", MemWriteData, 0);
        chk("rst_rvalid", {RValid0, RValid1}, 0);
        chk("rst_rdata", {RData0, RData1}, 0);
        Reset = 1'b0;

        // Give addresses 0..15 known contents.
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 1, i, 32'h1000_0000 + 32'(i * 7));
            step();
        end
        idle();
        step();

        // Arbitration table; the last winner is port 0 on entry.
        tbl = '{
            '{1,1,0,1}, '{1,1,1,0}, '{0,0,0,0}, '{1,0,1,0},
            '{1,1,0,1}, '{0,1,0,1}, '{0,1,0,1}, '{1,1,1,0},
            '{0,0,0,0}, '{0,1,0,1}, '{1,1,1,0}, '{1,1,0,1}
        };
        for (int i = 0; i < 12; i++) begin
            drive(0, tbl[i].r0, 0, i, '0);
            drive(1, tbl[i].r1, 0, i, '0);
            step();
            chk("tbl_ack0", s_ack0, tbl[i].a0);
            chk("tbl_ack1", s_ack1, tbl[i].a1);
        end
        idle();
        repeat (2) step();

        // Port 0 alone: write then read back.
        drive(0, 1, 1, 'h010, 32'hDEADBEEF);
        step();
        chk("p0_wr_ack", s_ack0, 1);
        drive(0, 1, 0, 'h010, '0);
        step();
        chk("p0_rd_ack", s_ack0, 1);
        idle();
        step();
        chk("p0_rv_early", s_rv0, 0);
        step();
        chk("p0_rv", s_rv0, 1);
        chk("p0_rdata", s_rd0, 32'hDEADBEEF);
        chk("p0_rv1_quiet", s_rv1, 0);

        // Continuous contention, alternating grants and returns.
        drive(0, 1, 1, 'h001, 32'h11);
        step();
        idle();
        drive(1, 1, 1, 'h002, 32'h22);
        step();
        for (int k = 0; k < 10; k++) begin
            drive(0, k < 8, 0, 'h001, '0);
            drive(1, k < 8, 0, 'h002, '0);
            step();
            chk("alt_ack0", s_ack0, (k < 8) && (k % 2 == 0));
            chk("alt_ack1", s_ack1, (k < 8) && (k % 2 == 1));
            if (k >= 2) begin
                chk("alt_rv0", s_rv0, k % 2 == 0);
                chk("alt_rv1", s_rv1, k % 2 == 1);
                if (k % 2 == 0) chk("alt_rd0", s_rd0, 32'h11);
                else            chk("alt_rd1", s_rd1, 32'h22);
            end
        end

        // Write by port 1 followed immediately by read of the same address by port 0.
        idle();
        drive(1, 1, 1, 'h100, 32'h5A5A);
        step();
        chk("raw_wr_ack1", s_ack1, 1);
        idle();
        drive(0, 1, 0, 'h100, '0);
        step();
        chk("raw_rd_ack0", s_ack0, 1);
        idle();
        step();
        step();
        chk("raw_rv0", s_rv0, 1);
        chk("raw_rd0", s_rd0, 32'h5A5A);

        // Idle gap after a port 1 grant, then port 1 alone.
        drive(1, 1, 0, 'h002, '0);
        step();
        chk("gap_pre_ack1", s_ack1, 1);
        idle();
        repeat (2) step();
        for (int k = 0; k < 3; k++) begin
            step();
            chk("gap_quiet", {s_rv0, s_rv1}, 0);
        end
        drive(1, 1, 0, 'h002, '0);
        step();
        chk("gap_ack1", s_ack1, 1);
        drive(0, 1, 0, 'h001, '0);
        step();
        chk("gap_tie_ack0", s_ack0, 1);
        idle();
        repeat (3) step();

        // Reset with reads in flight.
        drive(0, 1, 0, 'h003, '0);
        drive(1, 1, 0, 'h004, '0);
        repeat (3) step();
        idle();
        #2;
        Reset = 1'b1;
        #1;
        chk("mid_rst_rd_en", MemReadEn, 0);
        chk("mid_rst_wr_en", MemWriteEn, 0);
        chk("mid_rst_rvalid", {RValid0, RValid1}, 0);
        model_reset();
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("post_rst_quiet", {s_rv0, s_rv1}, 0);
        end
        drive(0, 1, 0, 'h005, '0);
        drive(1, 1, 0, 'h006, '0);
        step();
        chk("post_rst_ack0", s_ack0, 1);
        idle();
        repeat (3) step();

        // Random traffic; each requester holds its command until granted.
        for (int p = 0; p < 2; p++) q_act[p] = 0;
        for (int n = 0; n < 1500; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!q_act[p] || (p == 0 ? g0 : g1)) begin
                    q_act[p]  = ($urandom % 4) != 0;
                    q_wr[p]   = ($urandom % 3) == 0;
                    q_addr[p] = AW'($urandom % 16);
                    q_data[p] = $urandom;
                end
                drive(p, q_act[p], q_wr[p], int'(q_addr[p]), q_data[p]);
            end
            g0 = 0;
            g1 = 0;
            step();
        end
        idle();
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
